fifo_rx_handshake: RTL
======================

FIFO_RX_HANDSHAKE -- requirements
Module: fifo_rx_handshake

Interface
- REQ-001: Parameter DATA_WIDTH, default 32; flit width in bits.
- REQ-002: Parameter DEPTH, default 4; FIFO entries, power of two, minimum 2.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset; asynchronous, active-low.
- REQ-005: RX  input  DATA_WIDTH  flit from upstream sender; stable while DRTS=1.
- REQ-006: DRTS  input  1  request-to-send from upstream; held high until CTS seen.
- REQ-007: CTS  output  1  clear-to-send to upstream; registered; one-cycle pulse per accepted flit.
- REQ-008: read_en  input  1  pop request from downstream arbiter side.
- REQ-009: Data_out  output  DATA_WIDTH  head-of-FIFO flit; combinational from read pointer.
- REQ-010: empty  output  1  no entries stored.
- REQ-011: full  output  1  DEPTH entries stored.
- REQ-012: count  output  log2(DEPTH)+1  number of stored entries.

Function
- REQ-013: Accept condition per edge: accept = DRTS & ~CTS & ~full, using values before the edge.
- REQ-014: On an accept edge, the block SHALL write RX at write pointer, increment write pointer mod DEPTH, and set CTS=1 for exactly the next cycle.
- REQ-015: CTS SHALL return to 0 on the edge after it was set, regardless of DRTS; no two consecutive CTS=1 cycles.
- REQ-016: If DRTS stays high after a CTS pulse (next flit), the next accept SHALL occur no earlier than two edges after the previous accept; maximum rate is one flit per 2 cycles.
- REQ-017: While full=1, CTS SHALL stay 0 and no write SHALL occur; DRTS stays pending.
- REQ-018: Pop: on an edge with read_en=1 and empty=0, read pointer SHALL increment mod DEPTH; read_en with empty=1 SHALL be ignored (no pointer or count change).
- REQ-019: Simultaneous accept and pop on the same edge: count unchanged, both pointers advance.
- REQ-020: A pop on a full FIFO SHALL NOT enable an accept on the same edge; the accept occurs on the following edge at the earliest (full is evaluated pre-edge).
- REQ-021: Pointers SHALL wrap from DEPTH-1 to 0; count SHALL range 0..DEPTH and never over- or underflow.
- REQ-022: empty = (count==0), full = (count==DEPTH), both derived from registered count.
- REQ-023: Data_out SHALL equal the entry at read pointer; its value when empty=1 is don't-care but SHALL NOT be X after reset (storage reset to 0).
- REQ-024: Handshake state machine, two states: IDLE (CTS=0) -> ACK on accept; ACK (CTS=1) -> IDLE unconditionally.

Reset
- REQ-025: rst=0 SHALL immediately, without a clock edge, force CTS=0, count=0, empty=1, full=0, both pointers=0, and all storage entries=0.
- REQ-026: Reset asserted mid-handshake SHALL discard stored flits and any pending accept; after release, the first accept requires a fresh edge with DRTS=1.
- REQ-027: The first edge after rst deasserts SHALL be a normal functional edge.

Verification
- REQ-028: Reset, then DRTS=1, RX=0xA5A5A5A5 held -> CTS=1 in the cycle after the first edge; count=1; Data_out=0xA5A5A5A5; empty=0.
- REQ-029: DRTS held high with no reads, 5 flits offered, DEPTH=4 -> CTS pulses on edges 1,3,5,7; full=1 after edge 7; CTS stays 0 thereafter; count=4.
- REQ-030: Full FIFO, DRTS=1, read_en=1 for one edge -> count 3 after that edge; accept on next edge; count back to 4; the popped flit is the first written.
- REQ-031: count=2 with accept and read_en on the same edge -> count stays 2; write and read pointers each advance by 1.
- REQ-032: Empty FIFO, read_en=1 for 3 cycles -> count=0, pointers 0, empty=1 throughout.
- REQ-033: rst pulsed low asynchronously between edges while count=3 and CTS=1 -> CTS, count and pointers become 0 before the next edge; empty=1.

Source files
------------

// File: rtl/fifo_rx_handshake.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rx_handshake
// Brief    : RTS/CTS receive handshake feeding a power-of-two flit FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rx_handshake #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   RX,
  input  logic                    DRTS,
  output logic                    CTS,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   Data_out,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_PTR = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_cts;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]       r_wr_ptr;
  logic [ADDR_W-1:0]       r_rd_ptr;
  logic [ADDR_W:0]         r_count;

  logic                    w_accept;
  logic                    w_pop;
  logic                    w_empty;
  logic                    w_full;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  // r_cts blocks back-to-back accepts, limiting intake to one flit per two cycles
  assign w_accept = DRTS & ~r_cts & ~w_full;
  assign w_pop    = read_en & ~w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cts   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= ACK;
            r_cts   <= 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_cts   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_cts   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= RX;
        r_wr_ptr        <= r_wr_ptr + ONE_PTR;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  assign CTS      = r_cts;
  assign Data_out = r_mem[r_rd_ptr];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;

endmodule
`default_nettype wire
